// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory port and mem_responder.
interface mem_responder_if;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] rdata;
  logic        ready;
  logic        fault;

  modport master (
    output re, we, addr, wdata, size, ld_unsigned,
    input  rdata, ready, fault
  );

  modport slave (
    input  re, we, addr, wdata, size, ld_unsigned,
    output rdata, ready, fault
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM responder for the core's multi-cycle memory port: ready pulses WAIT_STATES+1 cycles after accept.
// No backpressure: strobes are held by the requester until the one-cycle ready pulse, which also carries fault.
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            resetn,
  mem_responder_if.slave  bus
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_word;
  logic [1:0]  r_size;
  logic        r_uns, r_re, r_we, r_fault;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept, w_commit, w_fault;
  logic [31:0] w_addr, w_wdata, w_off, w_wrep, w_shift, w_ext;
  logic [1:0]  w_size;
  logic        w_re, w_we;
  logic [3:0]  w_be;
  logic [IDX_W-1:0] w_idx;
  logic        w_ready, w_fault_o;
  logic [31:0] w_rdata;

  // In IDLE the live inputs are the request; afterwards the latched copies are.
  assign w_addr  = (r_state == S_IDLE) ? bus.addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? bus.wdata : r_wdata;
  assign w_size  = (r_state == S_IDLE) ? bus.size  : r_size;
  assign w_re    = (r_state == S_IDLE) ? bus.re    : r_re;
  assign w_we    = (r_state == S_IDLE) ? bus.we    : r_we;

  assign w_accept = (r_state == S_IDLE) && (bus.re || bus.we);
  assign w_commit = resetn && ((w_accept && (WAIT_STATES == 0)) ||
                               (r_state == S_WAIT && r_cnt == WS));

  // Subtraction wraps addresses below BASE_ADDR to huge offsets, so one compare covers both ends.
  assign w_off   = w_addr - BASE_ADDR;
  assign w_idx   = w_off[IDX_W+1:2];
  assign w_fault = (w_re && w_we) || (w_size == 2'd3) ||
                   (w_size == 2'd1 && w_addr[0]) ||
                   (w_size == 2'd2 && w_addr[1:0] != 2'b00) ||
                   ({1'b0, w_off} >= LIMIT);

  always_comb begin
    w_be   = 4'b0000;
    w_wrep = w_wdata;
    case (w_size)
      2'd0: begin
        w_be   = 4'b0001 << w_addr[1:0];
        w_wrep = {4{w_wdata[7:0]}};
      end
      2'd1: begin
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{w_wdata[15:0]}};
      end
      2'd2:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_we && !w_re && !w_fault && w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
        end
      end
      r_word <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_fault_o = 1'b0;
    w_rdata   = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == WS) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next    = S_IDLE;
        w_ready   = 1'b1;
        w_fault_o = r_fault;
        if (r_re && !r_we && !r_fault) begin
          w_rdata = w_ext;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'd1;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_size  <= bus.size;
        r_uns   <= bus.ld_unsigned;
        r_re    <= bus.re;
        r_we    <= bus.we;
        r_fault <= w_fault;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end
    end
  end

  assign w_shift = r_word >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = r_word;
    case (r_size)
      2'd0:    w_ext = r_uns ? {24'h0, w_shift[7:0]}  : {{24{w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_ext = r_uns ? {16'h0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = r_word;
    endcase
  end

  assign bus.ready = w_ready;
  assign bus.fault = w_fault_o;
  assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 1, 0, 15) driven through a shared stimulus port selected by sel.
module tb_mem_responder;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          sel = 1;

  logic        t_re = 1'b0, t_we = 1'b0, t_uns = 1'b0;
  logic [31:0] t_addr = 32'h0, t_wdata = 32'h0;
  logic [1:0]  t_size = 2'd0;
  logic        o_ready, o_fault;
  logic [31:0] o_rdata;

  logic [7:0]  mm [int unsigned];

  always #5 clock = ~clock;

  mem_responder_if if_ws0 ();
  mem_responder_if if_ws1 ();
  mem_responder_if if_ws15 ();

  assign if_ws0.re  = t_re && (sel == 0);
  assign if_ws0.we  = t_we && (sel == 0);
  assign if_ws1.re  = t_re && (sel == 1);
  assign if_ws1.we  = t_we && (sel == 1);
  assign if_ws15.re = t_re && (sel == 2);
  assign if_ws15.we = t_we && (sel == 2);
  assign if_ws0.addr = t_addr;   assign if_ws1.addr = t_addr;   assign if_ws15.addr = t_addr;
  assign if_ws0.wdata = t_wdata; assign if_ws1.wdata = t_wdata; assign if_ws15.wdata = t_wdata;
  assign if_ws0.size = t_size;   assign if_ws1.size = t_size;   assign if_ws15.size = t_size;
  assign if_ws0.ld_unsigned = t_uns;
  assign if_ws1.ld_unsigned = t_uns;
  assign if_ws15.ld_unsigned = t_uns;

  always_comb begin
    o_ready = if_ws1.ready; o_fault = if_ws1.fault; o_rdata = if_ws1.rdata;
    if (sel == 0) begin
      o_ready = if_ws0.ready; o_fault = if_ws0.fault; o_rdata = if_ws0.rdata;
    end else if (sel == 2) begin
      o_ready = if_ws15.ready; o_fault = if_ws15.fault; o_rdata = if_ws15.rdata;
    end
  end

  mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000))
    u_ws0 (.clock(clock), .resetn(resetn), .bus(if_ws0));
  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000))
    u_ws1 (.clock(clock), .resetn(resetn), .bus(if_ws1));
  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(15), .BASE_ADDR(32'h0000_0000))
    u_ws15 (.clock(clock), .resetn(resetn), .bus(if_ws15));

  // Drives one request, returns cycles from accept edge to ready (0 = never), response, and whether ready lingered.
  task automatic do_req(input logic rr, input logic ww, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u,
                        output int lat, output logic [31:0] rd, output logic flt, output logic held2);
    @(negedge clock);
    t_re = rr; t_we = ww; t_addr = a; t_wdata = d; t_size = sz; t_uns = u;
    @(posedge clock);
    lat = 0; rd = 32'h0; flt = 1'b0; held2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (o_ready) begin
        lat = k; rd = o_rdata; flt = o_fault;
        break;
      end
    end
    t_re = 1'b0; t_we = 1'b0;
    @(negedge clock);
    held2 = o_ready;
  endtask

  // Reference: byte-addressed memory and the access rules, no state machine.
  function automatic logic model_fault(input logic rr, input logic ww, input logic [31:0] a,
                                       input logic [1:0] sz);
    return (rr && ww) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
           (sz == 2'd2 && a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v = 32'h0;
    int n = 1 << sz;
    for (int i = 0; i < n; i++) v = v | (32'(mm[a + i]) << (8 * i));
    if (!u && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (!u && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      @(negedge clock);
      total++;
      if ({o_ready, o_fault, o_rdata} !== 34'h0)
        begin bad++; $display("FAIL reset_outputs dut%0d: ready=%b fault=%b rdata=%h, want 0/0/0", s, o_ready, o_fault, o_rdata); end
    end
    sel = 1;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic fl, h2;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, lat, rd, fl, h2);
    total++;
    if (lat != 2 || fl !== 1'b0 || rd !== 32'h0 || h2 !== 1'b0)
      begin bad++; $display("FAIL word_write: lat=%0d fault=%b rdata=%h held=%b, want 2/0/00000000/0", lat, fl, rd, h2); end
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b1, lat, rd, fl, h2);
    total++;
    if (lat != 2 || fl !== 1'b0 || rd !== 32'hDEAD_BEEF || h2 !== 1'b0)
      begin bad++; $display("FAIL word_read: lat=%0d fault=%b rdata=%h held=%b, want 2/0/deadbeef/0", lat, fl, rd, h2); end
  endtask

  task automatic test_extend();
    logic [31:0] a_t [3] = '{32'h13, 32'h13, 32'h10};
    logic [1:0]  s_t [3] = '{2'd0, 2'd0, 2'd1};
    logic        u_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] e_t [3] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_BEEF};
    int lat; logic [31:0] rd; logic fl, h2;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 1'b0, a_t[i], 32'h0, s_t[i], u_t[i], lat, rd, fl, h2);
      total++;
      if (lat != 2 || fl !== 1'b0 || rd !== e_t[i])
        begin bad++; $display("FAIL extend_%0d: lat=%0d fault=%b rdata=%h, want 2/0/%h", i, lat, fl, rd, e_t[i]); end
    end
  endtask

  task automatic test_subword();
    int lat; logic [31:0] rd; logic fl, h2;
    do_req(1'b0, 1'b1, 32'h12, 32'hFFFF_FF11, 2'd0, 1'b0, lat, rd, fl, h2);
    do_req(1'b0, 1'b1, 32'h10, 32'hAAAA_5566, 2'd1, 1'b0, lat, rd, fl, h2);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, lat, rd, fl, h2);
    total++;
    if (lat != 2 || fl !== 1'b0 || rd !== 32'hDE11_5566)
      begin bad++; $display("FAIL subword_merge: lat=%0d fault=%b rdata=%h, want 2/0/de115566", lat, fl, rd); end
  endtask

  task automatic test_faults();
    logic        r_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        w_t [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] a_t [5] = '{32'h12, 32'h11, 32'h10, 32'h10, 32'h1000};
    logic [1:0]  s_t [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
    int lat; logic [31:0] rd; logic fl, h2;
    for (int i = 0; i < 5; i++) begin
      do_req(r_t[i], w_t[i], a_t[i], 32'h7777_7777, s_t[i], 1'b0, lat, rd, fl, h2);
      total++;
      if (lat != 2 || fl !== 1'b1 || rd !== 32'h0 || h2 !== 1'b0)
        begin bad++; $display("FAIL fault_%0d: lat=%0d fault=%b rdata=%h held=%b, want 2/1/00000000/0", i, lat, fl, rd, h2); end
    end
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, lat, rd, fl, h2);
    total++;
    if (fl !== 1'b0 || rd !== 32'hDE11_5566)
      begin bad++; $display("FAIL fault_no_write: fault=%b rdata=%h, want 0/de115566", fl, rd); end
    do_req(1'b0, 1'b1, 32'hFFC, 32'h0BAD_CAFE, 2'd2, 1'b0, lat, rd, fl, h2);
    do_req(1'b1, 1'b0, 32'hFFC, 32'h0, 2'd2, 1'b0, lat, rd, fl, h2);
    total++;
    if (lat != 2 || fl !== 1'b0 || rd !== 32'h0BAD_CAFE)
      begin bad++; $display("FAIL last_word: lat=%0d fault=%b rdata=%h, want 2/0/0badcafe", lat, fl, rd); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic fl, h2;
    logic rr, ww, u, ef; logic [31:0] a, d, er; logic [1:0] sz;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      a = 32'h100 + 32'(4 * w);
      do_req(1'b0, 1'b1, a, d, 2'd2, 1'b0, lat, rd, fl, h2);
      for (int i = 0; i < 4; i++) mm[a + i] = d[8*i +: 8];
    end
    for (int n = 0; n < 60; n++) begin
      ww = $urandom_range(0, 1); rr = !ww; u = $urandom_range(0, 1);
      sz = 2'($urandom_range(0, 2)); d = $urandom;
      a = 32'h100 + 32'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0: sz = 2'd3;
        1: begin rr = 1'b1; ww = 1'b1; end
        2: a = 32'h1000 + 32'($urandom_range(0, 4095));
        default: ;
      endcase
      ef = model_fault(rr, ww, a, sz);
      er = (!ef && rr) ? model_load(a, sz, u) : 32'h0;
      if (!ef && ww) for (int i = 0; i < (1 << sz); i++) mm[a + i] = d[8*i +: 8];
      do_req(rr, ww, a, d, sz, u, lat, rd, fl, h2);
      total++;
      if (lat != 2 || fl !== ef || rd !== er || h2 !== 1'b0)
        begin bad++; $display("FAIL random_%0d re=%b we=%b a=%h sz=%0d u=%b: lat=%0d fault=%b rdata=%h held=%b, want 2/%b/%h/0",
                              n, rr, ww, a, sz, u, lat, fl, rd, h2, ef, er); end
    end
  endtask

  task automatic test_latency();
    int lat; logic [31:0] rd; logic fl, h2;
    sel = 0;
    do_req(1'b0, 1'b1, 32'h1004, 32'h1357_9BDF, 2'd2, 1'b0, lat, rd, fl, h2);
    total++;
    if (lat != 1 || fl !== 1'b0 || h2 !== 1'b0)
      begin bad++; $display("FAIL ws0_write: lat=%0d fault=%b held=%b, want 1/0/0", lat, fl, h2); end
    do_req(1'b1, 1'b0, 32'h1006, 32'h0, 2'd1, 1'b1, lat, rd, fl, h2);
    total++;
    if (lat != 1 || fl !== 1'b0 || rd !== 32'h0000_1357 || h2 !== 1'b0)
      begin bad++; $display("FAIL ws0_read: lat=%0d fault=%b rdata=%h held=%b, want 1/0/00001357/0", lat, fl, rd, h2); end
    do_req(1'b1, 1'b0, 32'h1100, 32'h0, 2'd2, 1'b0, lat, rd, fl, h2);
    total++;
    if (lat != 1 || fl !== 1'b1 || rd !== 32'h0)
      begin bad++; $display("FAIL ws0_above_range: lat=%0d fault=%b rdata=%h, want 1/1/00000000", lat, fl, rd); end
    do_req(1'b1, 1'b0, 32'h0FFC, 32'h0, 2'd2, 1'b0, lat, rd, fl, h2);
    total++;
    if (lat != 1 || fl !== 1'b1 || rd !== 32'h0)
      begin bad++; $display("FAIL ws0_below_base: lat=%0d fault=%b rdata=%h, want 1/1/00000000", lat, fl, rd); end
    sel = 2;
    do_req(1'b0, 1'b1, 32'h40, 32'hA5A5_0F0F, 2'd2, 1'b0, lat, rd, fl, h2);
    do_req(1'b1, 1'b0, 32'h41, 32'h0, 2'd0, 1'b0, lat, rd, fl, h2);
    total++;
    if (lat != 16 || fl !== 1'b0 || rd !== 32'h0000_000F || h2 !== 1'b0)
      begin bad++; $display("FAIL ws15_read: lat=%0d fault=%b rdata=%h held=%b, want 16/0/0000000f/0", lat, fl, rd, h2); end
    sel = 1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic fl, h2; logic seen = 1'b0;
    do_req(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 2'd2, 1'b0, lat, rd, fl, h2);
    @(negedge clock);
    t_we = 1'b1; t_re = 1'b0; t_addr = 32'h20; t_wdata = 32'h1234_5678; t_size = 2'd2;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b0; t_we = 1'b0;
    #1;
    total++;
    if ({o_ready, o_fault, o_rdata} !== 34'h0)
      begin bad++; $display("FAIL reset_mid_outputs: ready=%b fault=%b rdata=%h, want 0/0/0", o_ready, o_fault, o_rdata); end
    for (int k = 0; k < 3; k++) begin @(negedge clock); seen = seen | o_ready; end
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin @(negedge clock); seen = seen | o_ready; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_ready: saw ready=%b, want 0", seen); end
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, lat, rd, fl, h2);
    total++;
    if (lat != 2 || fl !== 1'b0 || rd !== 32'hCAFE_F00D)
      begin bad++; $display("FAIL reset_mid_contents: lat=%0d fault=%b rdata=%h, want 2/0/cafef00d", lat, fl, rd); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] mask = '0; logic [31:0] rd2 = 32'h0;
    @(negedge clock);
    t_re = 1'b1; t_we = 1'b0; t_addr = 32'h10; t_size = 2'd2; t_uns = 1'b0;
    @(posedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      mask[k] = o_ready;
      if (o_ready && k >= 5) begin rd2 = o_rdata; t_re = 1'b0; end
    end
    t_re = 1'b0;
    total++;
    if (mask !== 9'b0_0010_0100)
      begin bad++; $display("FAIL b2b_ready_cycles: mask=%b, want 000100100", mask); end
    total++;
    if (rd2 !== 32'hDE11_5566)
      begin bad++; $display("FAIL b2b_second_rdata: rdata=%h, want de115566", rd2); end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_subword();
    test_faults();
    test_random();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
